// File: rtl/unary_decode_14.sv
// unary_decode_14 -- receive side of the 14-bit unary adder.
// It follows the adder's read/write phase and frames the serial unary result on din.
// It counts the ones into a WIDTH-bit word and folds the adder carry into an overflow flag.
// The result is handed downstream on a valid/ready handshake.
// Optional build macro: UNARY_DEC_TRUNC_CHECK_EN. When it is defined, a frame cut short
// (phase falls while din is still 1) is reported on out_err. Otherwise out_err is tied 0.

module unary_decode_14 #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             phase,
  input  logic             din,
  input  logic             c_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_err,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] cnt;
  logic             sat;
  logic             ovf_acc;
  logic [WIDTH:0]   cnt_inc;

  logic             frame_start;
  logic             frame_skip;
  logic             count_one;
  logic             frame_end;
  logic             accept;
  logic             late_start;

  // Saturating increment: the MSB of the result reports that the counter was already full.
  function automatic logic [WIDTH:0] sat_inc(input logic [WIDTH-1:0] v);
    if (v == CNT_MAX) begin
      return {1'b1, v};
    end
    return {1'b0, v + WIDTH'(1)};
  endfunction

  // Per-cycle event decode. Stream events need en; the handshake does not.
  always_comb begin
    frame_start = (state == IDLE)  && en && !phase;
    frame_skip  = (state == READ)  && en &&  phase;
    count_one   = (state == COUNT) && en &&  din && phase;
    frame_end   = (state == COUNT) && en && (!din || !phase);
    accept      = (state == DONE)  && out_ready;
    late_start  = (state == DONE)  && en && !phase;
    cnt_inc     = sat_inc(cnt);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  // In COUNT, a zero on din ends the frame. A falling phase while din is still 1 also
  // ends it, as a truncated frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en && !phase)            state_nxt = READ;
      READ:    if (en && phase)             state_nxt = COUNT;
      COUNT:   if (en && (!din || !phase))  state_nxt = DONE;
      DONE:    if (out_ready)               state_nxt = IDLE;
      default:                              state_nxt = IDLE;
    endcase
  end

  // Output decode: the result is valid for as long as the FSM sits in DONE.
  always_comb begin
    out_valid = (state == DONE);
  end

  // Carry accumulation over the read phase, including the phase-rise edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_acc <= 1'b0;
    end else if (frame_start) begin
      ovf_acc <= c_in;
    end else if ((state == READ) && en) begin
      ovf_acc <= ovf_acc | c_in;
    end
  end

  // Ones counter.
  // It is cleared on the phase-rise (skip) edge, because dout lags phase by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (frame_skip) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (count_one) begin
      cnt <= cnt_inc[WIDTH-1:0];
      sat <= sat | cnt_inc[WIDTH];
    end
  end

  // Result capture at the end of the frame. The value is held after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else if (frame_end) begin
      out_data <= cnt;
      out_ovf  <= ovf_acc | sat;
    end
  end

  // Sticky overrun: a new read phase began while the previous result was still pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (late_start) begin
      overrun <= 1'b1;
    end
  end

`ifdef UNARY_DEC_TRUNC_CHECK_EN
  logic trunc;

  // A truncated frame is one where phase fell in COUNT while din still carried a one.
  always_comb begin
    trunc = (state == COUNT) && en && din && !phase;
  end

  // The error flag travels with the result and clears when the result is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_err <= 1'b0;
    end else if (frame_end) begin
      out_err <= trunc;
    end else if (accept) begin
      out_err <= 1'b0;
    end
  end
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_unary_decode_14.sv
// tb_unary_decode_14 -- self-checking bench for unary_decode_14.
// Each frame is described by its read-phase carries, its number of ones, an optional
// enable gap and truncation. The expected result is computed from those parameters.
// The expected out_err follows UNARY_DEC_TRUNC_CHECK_EN in the same way as the design.

module tb_unary_decode_14;

  localparam int W    = 14;
  localparam int MAXC = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         phase;
  logic         din;
  logic         c_in;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ovf;
  logic         out_err;
  logic         overrun;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  bit exp_overrun = 1'b0;

  unary_decode_14 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .phase     (phase),
    .din       (din),
    .c_in      (c_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_err   (out_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one complete frame from IDLE/READ and checks the captured result.
  task automatic run_frame(input int n_read, input int carry_at, input bit carry_skip,
                           input int n_ones, input int gap_at, input int gap_len,
                           input bit trunc, input string tag);
    int exp_data;
    bit exp_ovf;
    bit exp_err;
    exp_data = (n_ones > MAXC) ? MAXC : n_ones;
    exp_ovf  = (carry_at >= 0) || carry_skip || (n_ones > MAXC);
`ifdef UNARY_DEC_TRUNC_CHECK_EN
    exp_err  = trunc;
`else
    exp_err  = 1'b0;
`endif
    en  = 1'b1;
    din = 1'b0;
    for (int i = 0; i < n_read; i++) begin
      phase = 1'b0;
      c_in  = (i == carry_at);
      din   = 1'($urandom);
      tick();
    end
    phase = 1'b1;
    c_in  = carry_skip;
    din   = 1'($urandom);
    tick();
    for (int k = 0; k < n_ones; k++) begin
      if (k == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          en    = 1'b0;
          phase = 1'($urandom);
          din   = 1'($urandom);
          c_in  = 1'($urandom);
          tick();
        end
      end
      en    = 1'b1;
      phase = 1'b1;
      din   = 1'b1;
      c_in  = 1'($urandom);
      tick();
    end
    check({tag, " valid_early"}, out_valid, 0);
    if (trunc) begin
      phase = 1'b0;
      din   = 1'b1;
    end else begin
      phase = 1'b1;
      din   = 1'b0;
    end
    c_in = 1'($urandom);
    tick();
    phase = 1'b1;
    din   = 1'b0;
    c_in  = 1'b0;
    check({tag, " valid"},   out_valid, 1);
    check({tag, " data"},    out_data,  exp_data);
    check({tag, " ovf"},     out_ovf,   exp_ovf);
    check({tag, " err"},     out_err,   exp_err);
    check({tag, " overrun"}, overrun,   exp_overrun);
  endtask

  // Accepts the pending result with en low, since the handshake must not depend on en.
  task automatic accept(input int exp_data, input string tag);
    en        = 1'b0;
    phase     = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    en        = 1'b1;
    check({tag, " acc_valid"}, out_valid, 0);
    check({tag, " acc_data"},  out_data,  exp_data);
    check({tag, " acc_err"},   out_err,   0);
  endtask

  initial begin
    int n_read;
    int carry_at;
    bit carry_skip;
    int n_ones;
    int gap_at;
    int gap_len;
    bit trunc;
    int exp_d;

    rst_n     = 1'b0;
    en        = 1'b0;
    phase     = 1'b1;
    din       = 1'b0;
    c_in      = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst valid",   out_valid, 0);
    check("rst data",    out_data,  0);
    check("rst ovf",     out_ovf,   0);
    check("rst err",     out_err,   0);
    check("rst overrun", overrun,   0);
    rst_n = 1'b1;
    en    = 1'b1;
    tick();
    check("idle phase1 valid", out_valid, 0);

    // A=B=1 for 3 read cycles: 6 ones.
    run_frame(3, -1, 1'b0, 6, -1, 0, 1'b0, "six");
    accept(6, "six");

    // Zero-length stream.
    run_frame(2, -1, 1'b0, 0, -1, 0, 1'b0, "zero");
    accept(0, "zero");

    // Carry pulsed in the read phase, then 5 ones.
    run_frame(3, 1, 1'b0, 5, -1, 0, 1'b0, "carry");
    accept(5, "carry");

    // Carry present only on the phase-rise edge.
    run_frame(2, -1, 1'b1, 4, -1, 0, 1'b0, "skipcarry");
    accept(4, "skipcarry");

    // Result left pending, then a new read phase starts.
    run_frame(2, -1, 1'b0, 2, -1, 0, 1'b0, "ovr");
    for (int i = 0; i < 10; i++) begin
      en    = 1'b1;
      phase = 1'b1;
      tick();
    end
    check("ovr hold valid",   out_valid, 1);
    check("ovr hold overrun", overrun,   0);
    phase = 1'b0;
    tick();
    tick();
    exp_overrun = 1'b1;
    check("ovr overrun", overrun,   1);
    check("ovr data",    out_data,  2);
    check("ovr valid",   out_valid, 1);
    accept(2, "ovr");
    check("ovr sticky", overrun, 1);

    // A 4-cycle enable gap in the middle of COUNT, 7 ones in total.
    run_frame(2, -1, 1'b0, 7, 3, 4, 1'b0, "gap");
    accept(7, "gap");

    // Phase drops after 3 ones while din is still 1.
    run_frame(2, -1, 1'b0, 3, -1, 0, 1'b1, "trunc");
    accept(3, "trunc");

    // Asynchronous reset in the middle of COUNT.
    en    = 1'b1;
    phase = 1'b0;
    c_in  = 1'b1;
    tick();
    c_in  = 1'b0;
    phase = 1'b1;
    tick();
    din = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    exp_overrun = 1'b0;
    check("arst valid",   out_valid, 0);
    check("arst data",    out_data,  0);
    check("arst ovf",     out_ovf,   0);
    check("arst err",     out_err,   0);
    check("arst overrun", overrun,   0);
    din = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_frame(2, -1, 1'b0, 5, -1, 0, 1'b0, "postrst");
    accept(5, "postrst");

    // Randomised frames.
    for (int f = 0; f < 24; f++) begin
      n_read   = int'($urandom_range(1, 4));
      carry_at = -1;
      if ($urandom_range(0, 3) == 0) carry_at = int'($urandom_range(0, n_read - 1));
      carry_skip = ($urandom_range(0, 5) == 0);
      n_ones  = int'($urandom_range(0, 40));
      gap_at  = -1;
      gap_len = 0;
      if (n_ones > 0 && $urandom_range(0, 1) == 1) begin
        gap_at  = int'($urandom_range(0, n_ones - 1));
        gap_len = int'($urandom_range(1, 5));
      end
      trunc = ($urandom_range(0, 3) == 0);
      run_frame(n_read, carry_at, carry_skip, n_ones, gap_at, gap_len, trunc, "rand");
      exp_d = n_ones;
      accept(exp_d, "rand");
    end

    // Counter boundary: exactly full, then one past full.
    run_frame(1, -1, 1'b0, MAXC, -1, 0, 1'b0, "full");
    accept(MAXC, "full");
    run_frame(1, -1, 1'b0, MAXC + 1, -1, 0, 1'b0, "sat");
    accept(MAXC, "sat");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/unary_decode_14.md
# unary_decode_14

- Receive-side counterpart of the 14-bit unary adder: consumes the adder's serial unary result on `din` and returns it as a 14-bit binary word.
- Follows the adder's read/write phase signal, frames the stream, counts the ones and captures the adder's carry as an overflow flag.
- Presents the result on a valid/ready handshake to downstream binary logic.

## Interface
Parameters:
- `WIDTH`, 14, counter and output data width.

Ports:
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `en` input 1: stream-side enable, same as the adder's `en`.
- `phase` input 1: adder phase. 0 = read (operands in), 1 = write (unary result out).
- `din` input 1: unary stream from the adder `dout`, registered at source.
- `c_in` input 1: adder carry `C`.
- `out_ready` input 1: downstream accepts the result.
- `out_valid` output 1: result available.
- `out_data` output WIDTH: decoded count.
- `out_ovf` output 1: carry seen during the frame's read phase, or counter saturation.
- `out_err` output 1: truncated frame; present only with the macro, otherwise tied 0.
- `overrun` output 1: sticky; a frame started while the previous result was unaccepted.

## Operation
- FSM states: IDLE, READ, COUNT, DONE. Reset → IDLE.
- Stream-side transitions occur only on cycles with `en`=1. The output handshake is evaluated every cycle, regardless of `en`.
- IDLE:
  - `phase`=0 → READ; clear `ovf_acc` to `c_in`.
  - `phase`=1 → stay. No frame starts mid-write-phase.
- READ:
  - Each cycle, `ovf_acc |= c_in`.
  - `phase`=1 → COUNT, with `cnt`=0. This edge also ORs `c_in` into `ovf_acc`.
  - `din` is ignored on this skip edge because the adder's `dout` lags `phase` by one cycle.
- COUNT:
  - `din`=1 → `cnt`+1. At `cnt`=2^WIDTH−1, hold `cnt` and set the saturation flag.
  - `din`=0 → DONE. Register `out_data`=`cnt`, `out_ovf`=`ovf_acc`|sat, `out_valid`=1.
  - `phase`=0 while `din`=1 marks a truncated frame → DONE with the count so far; see Configuration.
- DONE:
  - `out_valid` held.
  - `out_valid`&`out_ready` → IDLE, `out_valid`=0. `out_data` and `out_ovf` retain their last value.
  - An `en` cycle with `phase`=0 arriving while in DONE sets `overrun`=1. That frame is dropped, and the block returns to IDLE only after acceptance.
- Zero-length stream: first COUNT sample is `din`=0 → `out_data`=0.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_ovf`=0, `out_err`=0, `overrun`=0; internal `cnt`=0, `ovf_acc`=0.
- Latency, for N ones and `en` held high:
  - Edge e0 is the first `phase`=1 sample (skip).
  - Ones are counted on e1..eN; the zero is sampled on eN+1.
  - `out_valid` is visible after eN+1, i.e. N+2 edges after `phase` rises.
- Accept: `out_valid` drops on the edge where `out_ready`=1. The earliest next frame then needs one IDLE edge with `phase`=0.
- `en`=0 freezes the FSM, `cnt` and `ovf_acc`. Gaps inside COUNT do not terminate the frame.
- Asynchronous reset mid-frame: all state is cleared immediately, and the partial count is discarded.

## Configuration
- `UNARY_DEC_TRUNC_CHECK_EN` defined:
  - A truncated frame (`phase`=0 in COUNT while `din`=1) sets `out_err`=1 with the result.
  - `out_err` clears on acceptance.
- Not defined:
  - `out_err` is constant 0.
  - Truncation ends the frame normally with the partial count.

## Test plan
- Adder inputs A=B=1 for 3 read cycles, then `phase`=1 → `din` gives 6 ones then 0; `out_data`=6, `out_ovf`=0, `out_valid` after 8 edges.
- `phase`=1 with `din`=0 immediately → `out_data`=0, `out_valid`=1.
- `c_in`=1 pulsed for one read-phase cycle, then 5 ones → `out_data`=5, `out_ovf`=1.
- `out_ready`=0 for 10 cycles, then a new read phase begins → `overrun`=1, `out_data` unchanged. `out_ready`=1 → `out_valid`=0.
- `en` low for 4 cycles mid-COUNT with 7 total ones → `out_data`=7.
- With the macro, `phase` drops after 3 ones with `din`=1 → `out_data`=3, `out_err`=1. Without it: `out_err`=0.
- `rst_n` asserted mid-COUNT → all outputs 0 on the same cycle; the next frame decodes correctly.
